// File: rtl/cavlc_runbefore_ctrl.sv
// cavlc_runbefore_ctrl
// Per-4x4-block sequencer for the CAVLC run_before encoder. The controller
// accepts one block descriptor and latches it. It then drives the encoder
// clear, load and step strobes for exactly the required number of cycles.
// Finally it hands the accumulated code/length to the bitstream packer over
// a valid/ready handshake.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   h264_reset            synchronous frame soft reset (same effect as rst)
//   blk_valid/blk_ready   descriptor handshake; blk_total_zero, blk_rb_cnt
//   enc_rst/enc_load      encoder clear / zero_left load strobes
//   start_enc             encoder step enable, one per run_before entry
//   enc_total_zero        latched total_zero, held for the block
//   enc_rb_cnt            latched entry count clamped to MAX_RB, held for the block
//   rb_code/rb_bit        encoder accumulated code and length
//   out_valid/out_ready   result handshake; out_code/out_bit are zero outside DONE
//   busy                  controller not idle
//   cfg_err               one-cycle pulse when the descriptor count exceeded MAX_RB
//   blk_cnt               completed blocks, wraps modulo 2^CNT_W
module cavlc_runbefore_ctrl #(
  parameter int CNT_W  = 16,
  parameter int MAX_RB = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             h264_reset,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [4:0]       blk_total_zero,
  input  logic [4:0]       blk_rb_cnt,
  output logic             enc_rst,
  output logic             enc_load,
  output logic             start_enc,
  output logic [4:0]       enc_total_zero,
  output logic [4:0]       enc_rb_cnt,
  input  logic [31:0]      rb_code,
  input  logic [4:0]       rb_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_code,
  output logic [4:0]       out_bit,
  output logic             busy,
  output logic             cfg_err,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [2:0] {IDLE, CLR, LOAD, RUN, DONE} state_t;

  localparam logic [4:0] MAX_RB_V = 5'(MAX_RB);

  state_t     state;
  logic [4:0] run_cnt;

  // Strobes are registered: each one is set on the edge that enters the
  // state it belongs to, so it is high for exactly the cycles spent there.
  always_ff @(posedge clk) begin
    if (rst || h264_reset) begin
      state          <= IDLE;
      blk_ready      <= 1'b1;
      busy           <= 1'b0;
      enc_rst        <= 1'b0;
      enc_load       <= 1'b0;
      start_enc      <= 1'b0;
      out_valid      <= 1'b0;
      cfg_err        <= 1'b0;
      blk_cnt        <= '0;
      enc_total_zero <= '0;
      enc_rb_cnt     <= '0;
      run_cnt        <= '0;
    end else begin
      enc_rst  <= 1'b0;
      enc_load <= 1'b0;
      cfg_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (blk_valid) begin
            enc_total_zero <= blk_total_zero;
            enc_rb_cnt     <= (blk_rb_cnt > MAX_RB_V) ? MAX_RB_V : blk_rb_cnt;
            cfg_err        <= (blk_rb_cnt > MAX_RB_V);
            enc_rst        <= 1'b1;
            blk_ready      <= 1'b0;
            busy           <= 1'b1;
            state          <= CLR;
          end
        end
        CLR: begin
          // Nothing to encode: the freshly cleared encoder already holds
          // the (empty) result.
          if (enc_rb_cnt == '0 || enc_total_zero == '0) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            enc_load <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          run_cnt   <= enc_rb_cnt;
          start_enc <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          if (run_cnt == 5'd1) begin
            start_enc <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            run_cnt <= run_cnt - 5'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            blk_ready <= 1'b1;
            busy      <= 1'b0;
            blk_cnt   <= blk_cnt + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // out_valid is high exactly in DONE, so it gates the pass-through.
  always_comb begin
    out_code = '0;
    out_bit  = '0;
    if (out_valid) begin
      out_code = rb_code;
      out_bit  = rb_bit;
    end
  end

endmodule

// File: tb/tb_cavlc_runbefore_ctrl.sv
// Self-checking bench for cavlc_runbefore_ctrl. A small behavioural encoder
// stub appends a 2-bit piece per step, and the pieces are taken from a
// per-block seed. Expected strobe timing and the expected result are
// derived from the descriptor alone.
module tb_cavlc_runbefore_ctrl;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, h264_reset, blk_valid, out_ready;
  logic [4:0]    blk_total_zero, blk_rb_cnt;
  logic          blk_ready, enc_rst, enc_load, start_enc, out_valid, busy, cfg_err;
  logic [4:0]    enc_total_zero, enc_rb_cnt, out_bit, rb_bit;
  logic [31:0]   rb_code, out_code;
  logic [CW-1:0] blk_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0]   seed = '0;
  logic [CW-1:0] model_cnt = '0;

  cavlc_runbefore_ctrl #(.CNT_W(CW), .MAX_RB(15)) dut (
    .clk(clk), .rst(rst), .h264_reset(h264_reset),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_total_zero(blk_total_zero), .blk_rb_cnt(blk_rb_cnt),
    .enc_rst(enc_rst), .enc_load(enc_load), .start_enc(start_enc),
    .enc_total_zero(enc_total_zero), .enc_rb_cnt(enc_rb_cnt),
    .rb_code(rb_code), .rb_bit(rb_bit),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_bit(out_bit),
    .busy(busy), .cfg_err(cfg_err), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  // Encoder stub: clear, reset the step index on load, append one piece per step.
  int unsigned step = 0;
  always_ff @(posedge clk) begin
    if (enc_rst) begin
      rb_code <= '0;
      rb_bit  <= '0;
    end else if (enc_load) begin
      step <= 0;
    end else if (start_enc) begin
      rb_code <= (rb_code << 2) | ((seed >> (2 * step)) & 32'd3);
      rb_bit  <= rb_bit + 5'd2;
      step    <= step + 1;
    end
  end

  logic [43:0] obs_vec;
  assign obs_vec = {blk_ready, busy, enc_rst, enc_load, start_enc, out_valid, cfg_err,
                    out_code, out_bit};

  localparam logic [43:0] IDLE_VEC = {7'b1000000, 32'd0, 5'd0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One descriptor, accepted at edge T; checks every cycle until back in IDLE.
  task automatic run_block(input logic [4:0] tz, input logic [4:0] rb,
                           input int unsigned stall, input logic [31:0] sd);
    int unsigned n, done_k;
    bit          skip;
    logic [31:0] ecode;
    logic [4:0]  ebit;
    logic [43:0] ev;
    n      = (rb > 5'd15) ? 15 : int'(rb);
    skip   = (n == 0) || (tz == 0);
    done_k = skip ? 2 : 3 + n;
    ecode  = '0;
    ebit   = '0;
    if (!skip) begin
      for (int i = 0; i < int'(n); i++) ecode = (ecode << 2) | ((sd >> (2 * i)) & 32'd3);
      ebit = 5'(2 * n);
    end
    chk("ready_before", {63'd0, blk_ready}, 64'd1);
    seed           = sd;
    blk_total_zero = tz;
    blk_rb_cnt     = rb;
    blk_valid      = 1'b1;
    tick();
    blk_valid      = 1'b0;
    blk_total_zero = 5'($urandom);
    blk_rb_cnt     = 5'($urandom);
    for (int unsigned k = 1; k <= done_k + stall; k++) begin
      ev = {1'b0, 1'b1, (k == 1), (!skip && k == 2), (!skip && k >= 3 && k <= 2 + n),
            (k >= done_k), (k == 1 && rb > 5'd15),
            (k >= done_k) ? ecode : 32'd0, (k >= done_k) ? ebit : 5'd0};
      chk("cycle", {20'd0, obs_vec}, {20'd0, ev});
      chk("latched", {54'd0, enc_total_zero, enc_rb_cnt}, {54'd0, tz, 5'(n)});
      out_ready = (k == done_k + stall);
      tick();
    end
    out_ready = 1'b0;
    model_cnt++;
    chk("back_idle", {20'd0, obs_vec}, {20'd0, IDLE_VEC});
    chk("blk_cnt", {{(64-CW){1'b0}}, blk_cnt}, {{(64-CW){1'b0}}, model_cnt});
  endtask

  initial begin
    rst = 1'b1; h264_reset = 1'b0; blk_valid = 1'b0; out_ready = 1'b0;
    blk_total_zero = '0; blk_rb_cnt = '0;
    repeat (3) tick();
    chk("reset_in", {20'd0, obs_vec}, {20'd0, IDLE_VEC});
    rst = 1'b0;
    tick();
    chk("reset_out", {20'd0, obs_vec}, {20'd0, IDLE_VEC});
    chk("reset_regs", {64'(enc_total_zero), 64'(enc_rb_cnt) | 64'(blk_cnt)}, 128'd0);

    // Directed cases.
    run_block(5'd3, 5'd2, 0, 32'h2);         // out_code 8, out_bit 4
    run_block(5'd0, 5'd5, 0, 32'hffff_ffff); // skip on total_zero
    run_block(5'd3, 5'd2, 3, 32'h2);         // packer stall
    run_block(5'd15, 5'd20, 0, $urandom);    // clamp + cfg_err
    run_block(5'd7, 5'd0, 1, $urandom);      // skip on count
    run_block(5'd9, 5'd1, 0, $urandom);      // single step

    // Soft reset together with a descriptor: descriptor is dropped.
    blk_total_zero = 5'd4; blk_rb_cnt = 5'd3; blk_valid = 1'b1; h264_reset = 1'b1;
    tick();
    blk_valid = 1'b0; h264_reset = 1'b0;
    model_cnt = '0;
    chk("rst_vs_valid", {20'd0, obs_vec}, {20'd0, IDLE_VEC});
    chk("rst_vs_valid_regs", {54'd0, enc_total_zero, enc_rb_cnt}, 64'd0);
    chk("rst_vs_valid_cnt", {{(64-CW){1'b0}}, blk_cnt}, 64'd0);

    // Abort during the second RUN cycle.
    run_block(5'd6, 5'd3, 0, $urandom);
    seed = $urandom;
    blk_total_zero = 5'd5; blk_rb_cnt = 5'd4; blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    repeat (3) tick();
    chk("abort_in_run", {63'd0, start_enc}, 64'd1);
    h264_reset = 1'b1;
    tick();
    h264_reset = 1'b0;
    model_cnt = '0;
    chk("abort_idle", {20'd0, obs_vec}, {20'd0, IDLE_VEC});
    chk("abort_cnt", {{(64-CW){1'b0}}, blk_cnt}, 64'd0);
    for (int i = 0; i < 20; i++) begin
      out_ready = 1'(i & 1);
      tick();
      chk("abort_no_valid", {20'd0, obs_vec}, {20'd0, IDLE_VEC});
    end
    out_ready = 1'b0;

    // Randomized descriptors with random stalls and idle gaps.
    for (int i = 0; i < 40; i++) begin
      run_block(5'($urandom), 5'($urandom), $urandom_range(0, 3), $urandom);
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk("idle_gap", {20'd0, obs_vec}, {20'd0, IDLE_VEC});
      end
    end

    // Counter wrap: 2^CW + 1 back-to-back skip blocks from zero.
    h264_reset = 1'b1;
    tick();
    h264_reset = 1'b0;
    model_cnt = '0;
    chk("wrap_start", {{(64-CW){1'b0}}, blk_cnt}, 64'd0);
    for (int i = 0; i < (1 << CW) + 1; i++) begin
      if (i & 1) run_block(5'd0, 5'($urandom), 0, $urandom);
      else run_block(5'($urandom), 5'd0, 0, $urandom);
    end
    chk("wrap_end", {{(64-CW){1'b0}}, blk_cnt}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cavlc_runbefore_ctrl.md
# cavlc_runbefore_ctrl

Per-4x4-block sequencer for the CAVLC run_before encoder. It accepts one block descriptor at a time from the coefficient scan stage and drives the encoder's clear, load and encode strobes for exactly the required number of cycles. It then presents the finished run_before code/length to the bitstream packer over a valid/ready handshake. It sits between the zigzag/scan stage and the CAVLC bit packer.

## Interface
- CNT_W, 16: width of the processed-block counter.
- MAX_RB, 15: largest legal run_before entry count per block.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- h264_reset  in  1  synchronous soft reset for a new frame; same effect as rst on this block
- blk_valid  in  1  block descriptor valid
- blk_ready  out  1  controller can accept a descriptor
- blk_total_zero  in  5  total_zeros of the block
- blk_rb_cnt  in  5  number of run_before entries to encode
- enc_rst  out  1  encoder clear strobe
- enc_load  out  1  encoder zero_left load strobe
- start_enc  out  1  encoder step enable
- enc_total_zero  out  5  latched total_zero, held for the block
- enc_rb_cnt  out  5  latched, clamped entry count, held for the block
- rb_code  in  32  encoder accumulated code
- rb_bit  in  5  encoder accumulated length
- out_valid  out  1  result valid to packer
- out_ready  in  1  packer accepts result
- out_code  out  32  run_before code, right-aligned
- out_bit  out  5  run_before length
- busy  out  1  state != IDLE
- cfg_err  out  1  one-cycle pulse when blk_rb_cnt > MAX_RB
- blk_cnt  out  CNT_W  blocks completed; wraps modulo 2^CNT_W

## Operation
- States: IDLE, CLR, LOAD, RUN, DONE.
- **IDLE**
  - blk_ready = 1.
  - On blk_valid: latch blk_total_zero into enc_total_zero, and min(blk_rb_cnt, MAX_RB) into enc_rb_cnt.
  - If blk_rb_cnt > MAX_RB, pulse cfg_err in the following cycle.
  - Go to CLR.
- **CLR**
  - enc_rst = 1 for one cycle.
  - If the latched count is 0 or the latched total_zero is 0 (skip case), go to DONE; otherwise go to LOAD.
- **LOAD**
  - enc_load = 1 for one cycle.
  - Load the run counter with enc_rb_cnt.
  - Go to RUN.
- **RUN**
  - start_enc = 1 each cycle; decrement the run counter.
  - When the counter reaches 1, go to DONE after that cycle.
  - Exactly enc_rb_cnt start_enc cycles are issued.
- **DONE**
  - out_valid = 1; out_code = rb_code and out_bit = rb_bit, passed through.
  - All strobes stay low, so the encoder outputs are stable.
  - On out_ready: increment blk_cnt and go to IDLE.
- Outside DONE, out_code and out_bit are 0.
- Strobes are mutually exclusive: enc_rst, enc_load and start_enc are never high in the same cycle.
- rst or h264_reset from any state:
  - Next cycle is IDLE with all strobes 0 and out_valid 0.
  - enc_total_zero, enc_rb_cnt and blk_cnt are cleared to 0.
  - An in-flight block is discarded; no out_valid is issued for it.
- h264_reset together with blk_valid: reset wins; the descriptor is not accepted.

## Timing
- Reset values: blk_ready 1, busy 0, enc_rst 0, enc_load 0, start_enc 0, out_valid 0, out_code 0, out_bit 0, cfg_err 0, blk_cnt 0, enc_total_zero 0, enc_rb_cnt 0.
- Descriptor accepted at edge T:
  - CLR in cycle T+1, LOAD in T+2.
  - RUN in T+3 .. T+2+N.
  - out_valid first high in T+3+N, where N is the clamped count.
- Skip case: out_valid in T+2, with out_code 0 and out_bit 0 (the encoder has just been cleared).
- out_valid stays high, with out_code/out_bit stable, until out_ready is sampled high.
- Minimum block period is N+4 cycles plus any packer stall; IDLE always lasts at least one cycle between blocks.
- blk_cnt updates on the edge where out_valid && out_ready.

## Test plan
- blk_total_zero=3, blk_rb_cnt=2, encoder list {1,2}, accept at T → enc_rst at T+1, enc_load at T+2, start_enc at T+3..T+4; out_valid at T+5 with out_code=32'h8, out_bit=4.
- blk_total_zero=0, blk_rb_cnt=5 → no enc_load and no start_enc; out_valid at T+2 with out_code=0, out_bit=0.
- Case 1 with out_ready low for 3 cycles → out_valid and out_code=8 held for 4 cycles; blk_cnt increments once; blk_ready returns the next cycle.
- blk_rb_cnt=20, blk_total_zero=15 → cfg_err pulse at T+1, enc_rb_cnt=15, exactly 15 start_enc cycles, out_valid at T+18.
- h264_reset asserted during the 2nd RUN cycle → next cycle IDLE, start_enc 0, blk_ready 1, blk_cnt 0; no out_valid for the aborted block.
- 2^16+1 back-to-back skip blocks with out_ready tied high → blk_cnt wraps to 1; no strobe overlap at any cycle.
